// File: rtl/sisc_ir_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sisc_ir_sequencer_pkg
// Brief    : Shared opcodes, NOP word and state encoding for the ir sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sisc_ir_sequencer_pkg;

    localparam int          c_OPC_W  = 4;
    localparam logic [3:0]  c_OP_NOP = 4'h0;
    localparam logic [3:0]  c_OP_HLT = 4'hF;
    localparam logic [31:0] c_IR_NOP = {c_OP_NOP, 28'h0};

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_RUN  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

    function automatic logic is_hlt(input logic [c_OPC_W-1:0] opc);
        return opc == c_OP_HLT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sisc_ir_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sisc_ir_sequencer_if
// Brief    : Program-store write bus between loader (master) and sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface sisc_ir_sequencer_if #(
    parameter int IR_W   = 32,
    parameter int ADDR_W = 6
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [IR_W-1:0]   wr_data;
    logic              wr_err;

    modport master (output wr_en, output wr_addr, output wr_data, input  wr_err);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data, output wr_err);
endinterface
`default_nettype wire

// File: rtl/sisc_ir_sequencer_prog_mem.sv
`default_nettype none
// ============================================================================
// Module   : sisc_ir_sequencer_prog_mem
// Brief    : DEPTH x IR_W program store, one write port, one synchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module sisc_ir_sequencer_prog_mem #(
    parameter int IR_W   = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  wire logic              i_clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [IR_W-1:0]   i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [IR_W-1:0]   o_rdata
);
    logic [IR_W-1:0] r_mem [DEPTH];
    logic [IR_W-1:0] r_rdata;

    // Write-first so a word written in the start cycle is the one fetched.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/sisc_ir_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sisc_ir_sequencer
// Brief    : Plays a loaded program onto the SISC ir port, HOLD_CYC cycles/word.
// Revision : 1.0 - initial release
// ============================================================================
module sisc_ir_sequencer
    import sisc_ir_sequencer_pkg::*;
#(
    parameter int IR_W     = 32,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int HOLD_CYC = 5
) (
    input  wire logic            clk,
    input  wire logic            rst,
    sisc_ir_sequencer_if.slave   prog,
    input  wire logic [ADDR_W:0] prog_len,
    input  wire logic            loop_en,
    input  wire logic            start,
    input  wire logic            stall,
    output logic [IR_W-1:0]      ir,
    output logic                 ir_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 halted,
    output logic [ADDR_W-1:0]    pc
);
    localparam int                 c_HOLD_W    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W:0]    c_DEPTH     = (ADDR_W + 1)'(DEPTH);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
    logic [c_HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [ADDR_W:0]     r_len, w_len_nxt;
    logic                r_loop, w_loop_nxt;
    logic                r_halted, w_halted_nxt;
    logic                r_wr_err;
    logic                w_run, w_we, w_last_word;
    logic [IR_W-1:0]     w_rdata;

    assign w_run       = (r_state == c_ST_RUN);
    assign w_we        = prog.wr_en & ~w_run;
    assign w_last_word = ({1'b0, r_pc} == (r_len - (ADDR_W + 1)'(1)));

    // Read address is next cycle's pc, so the fetched word lands with the pc update.
    sisc_ir_sequencer_prog_mem #(
        .IR_W   (IR_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (prog.wr_addr),
        .i_wdata (prog.wr_data),
        .i_raddr (w_pc_nxt),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_hold_nxt   = r_hold;
        w_len_nxt    = r_len;
        w_loop_nxt   = r_loop;
        w_halted_nxt = r_halted;
        case (r_state)
            c_ST_RUN: begin
                if (!stall) begin
                    if (r_hold == c_HOLD_LAST) begin
                        w_hold_nxt = '0;
                        if (is_hlt(w_rdata[IR_W-1 -: c_OPC_W])) begin
                            w_state_nxt  = c_ST_DONE;
                            w_halted_nxt = 1'b1;
                        end else if (w_last_word) begin
                            if (r_loop) begin
                                w_pc_nxt = '0;
                            end else begin
                                w_state_nxt = c_ST_DONE;
                            end
                        end else begin
                            w_pc_nxt = r_pc + ADDR_W'(1);
                        end
                    end else begin
                        w_hold_nxt = r_hold + c_HOLD_W'(1);
                    end
                end
            end
            default: begin
                if (start) begin
                    w_len_nxt    = (prog_len > c_DEPTH) ? c_DEPTH : prog_len;
                    w_loop_nxt   = loop_en;
                    w_halted_nxt = 1'b0;
                    w_pc_nxt     = '0;
                    w_hold_nxt   = '0;
                    w_state_nxt  = (prog_len == '0) ? c_ST_DONE : c_ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_pc     <= '0;
            r_hold   <= '0;
            r_len    <= '0;
            r_loop   <= 1'b0;
            r_halted <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_hold   <= w_hold_nxt;
            r_len    <= w_len_nxt;
            r_loop   <= w_loop_nxt;
            r_halted <= w_halted_nxt;
            r_wr_err <= prog.wr_en & w_run;
        end
    end

    assign ir          = w_run ? w_rdata : IR_W'(c_IR_NOP);
    assign ir_valid    = w_run;
    assign busy        = w_run;
    assign done        = (r_state == c_ST_DONE);
    assign halted      = r_halted;
    assign pc          = r_pc;
    assign prog.wr_err = r_wr_err;
endmodule
`default_nettype wire
